// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers x/y/video_on from hsync/vsync pulses,
// checks line and frame periods and tracks raster lock.
module vga_sync_decoder #(
  parameter int HD         = 640,
  parameter int HB         = 16,
  parameter int HR         = 96,
  parameter int HTOTAL     = 800,
  parameter int VD         = 480,
  parameter int VB         = 33,
  parameter int VTOTAL     = 525,
  parameter int LOCK_LINES = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

  localparam logic [9:0]  X_LOAD  = 10'(HD + HB);
  localparam logic [9:0]  Y_LOAD  = 10'(VD + VB);
  localparam logic [9:0]  H_MAX   = 10'(HTOTAL - 1);
  localparam logic [9:0]  V_MAX   = 10'(VTOTAL - 1);
  localparam logic [9:0]  X_VIS   = 10'(HD);
  localparam logic [9:0]  Y_VIS   = 10'(VD);
  localparam logic [10:0] P_LINE  = 11'(HTOTAL);
  localparam logic [10:0] P_TOUT  = 11'(2 * HTOTAL - 1);
  localparam logic [9:0]  L_FRAME = 10'(VTOTAL);
  localparam logic [7:0]  G_LOCK  = 8'(LOCK_LINES);

  if (HD + HB + HR >= HTOTAL) begin : g_bad_htiming
    $error("hsync pulse does not fit inside the line");
  end

  state_t      r_state;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic        r_armed;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_lines;
  logic [10:0] r_per;
  logic [7:0]  r_good;
  logic        r_video;
  logic        r_locked;
  logic        r_herr;
  logic        r_verr;
  logic [7:0]  r_errcnt;

  logic        w_hrise;
  logic        w_vrise;
  logic        w_hwrap;
  logic        w_tout;
  logic        w_hbad;
  logic        w_vbad;
  logic [9:0]  w_x_nx;
  logic [9:0]  w_y_nx;
  logic [10:0] w_per_nx;
  logic [9:0]  w_lines_nx;
  logic [7:0]  w_good_upd;
  logic [7:0]  w_good_nx;
  state_t      w_st_nx;
  logic        w_armed_nx;
  logic        w_seth;
  logic        w_setv;
  logic        w_lose;
  logic        w_lock_nx;
  logic        w_vid_nx;

  always_comb begin
    w_hrise = hsync & ~r_hs_prev;
    w_vrise = vsync & ~r_vs_prev;
    w_hwrap = (r_x == H_MAX);
    w_tout  = ~w_hrise & (r_per == P_TOUT);
    w_hbad  = w_hrise & (r_per != P_LINE);
    w_vbad  = w_vrise & (r_lines != L_FRAME);

    if (w_hrise)      w_x_nx = X_LOAD;
    else if (w_hwrap) w_x_nx = 10'd0;
    else              w_x_nx = r_x + 10'd1;

    if (w_vrise)      w_y_nx = Y_LOAD;
    else if (w_hwrap) w_y_nx = (r_y == V_MAX) ? 10'd0 : r_y + 10'd1;
    else              w_y_nx = r_y;

    if (w_hrise)              w_per_nx = 11'd1;
    else if (&r_per)          w_per_nx = r_per;
    else                      w_per_nx = r_per + 11'd1;

    // an hsync rise on the vsync tick belongs to the new frame
    if (w_vrise)              w_lines_nx = {9'd0, w_hrise};
    else if (w_hrise && !(&r_lines))
                              w_lines_nx = r_lines + 10'd1;
    else                      w_lines_nx = r_lines;

    if (!w_hrise)             w_good_upd = r_good;
    else if (w_hbad)          w_good_upd = 8'd0;
    else if (r_good >= G_LOCK) w_good_upd = r_good;
    else                      w_good_upd = r_good + 8'd1;

    w_st_nx    = r_state;
    w_armed_nx = r_armed;
    w_good_nx  = 8'd0;
    w_seth     = 1'b0;
    w_setv     = 1'b0;
    w_lose     = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_hrise) begin
          w_st_nx    = HLOCK;
          w_armed_nx = 1'b0;
        end
      end
      HLOCK: begin
        w_good_nx = w_good_upd;
        if (w_vrise) begin
          w_armed_nx = 1'b1;
          if (r_armed && !w_vbad && w_good_upd >= G_LOCK)
            w_st_nx = LOCKED;
        end
      end
      LOCKED: begin
        w_seth = w_hbad;
        w_setv = w_vbad;
        if (w_hbad || w_vbad) begin
          w_st_nx = SEARCH;
          w_lose  = 1'b1;
        end
      end
      default: w_st_nx = SEARCH;
    endcase
    if (w_tout) begin
      w_st_nx   = SEARCH;
      w_good_nx = 8'd0;
      if (r_state == LOCKED) begin
        w_seth = 1'b1;
        w_lose = 1'b1;
      end
    end

    w_lock_nx = (w_st_nx == LOCKED);
    w_vid_nx  = w_lock_nx && (w_x_nx < X_VIS) && (w_y_nx < Y_VIS);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_armed   <= 1'b0;
      r_x       <= 10'd0;
      r_y       <= 10'd0;
      r_lines   <= 10'd0;
      r_per     <= 11'd0;
      r_good    <= 8'd0;
      r_video   <= 1'b0;
      r_locked  <= 1'b0;
      r_herr    <= 1'b0;
      r_verr    <= 1'b0;
      r_errcnt  <= 8'd0;
    end else if (p_tick) begin
      r_state   <= w_st_nx;
      r_hs_prev <= hsync;
      r_vs_prev <= vsync;
      r_armed   <= w_armed_nx;
      r_x       <= w_x_nx;
      r_y       <= w_y_nx;
      r_lines   <= w_lines_nx;
      r_per     <= w_per_nx;
      r_good    <= w_good_nx;
      r_video   <= w_vid_nx;
      r_locked  <= w_lock_nx;
      r_herr    <= r_herr | w_seth;
      r_verr    <= r_verr | w_setv;
      if (w_lose && !(&r_errcnt))
        r_errcnt <= r_errcnt + 8'd1;
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign video_on = r_video;
  assign locked   = r_locked;
  assign h_err    = r_herr;
  assign v_err    = r_verr;
  assign err_cnt  = r_errcnt;

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: samples `hsync`/`vsync` on each pixel tick, locks onto the 800x525 (640x480 visible) raster, and reconstructs pixel coordinates and `video_on` from the sync pulses alone. Checks line and frame periods, reports lock and sync errors, and sits downstream of the display timing path as a self-check and frame-capture front end.

## Interface
- `HD`, 640, visible pixels per line
- `HB`, 16, ticks from end of visible to hsync rise
- `HR`, 96, hsync width in ticks
- `HTOTAL`, 800, ticks per line
- `VD`, 480, visible lines per frame
- `VB`, 33, lines from end of visible to vsync rise
- `VTOTAL`, 525, lines per frame
- `LOCK_LINES`, 4, consecutive good lines required before frame check
- `clk_100MHz`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `p_tick`  in  1  pixel-rate enable, one `clk_100MHz` cycle wide, 1 in 4
- `hsync`  in  1  horizontal sync, active-high during retrace
- `vsync`  in  1  vertical sync, active-high during retrace
- `x`  out  10  recovered horizontal position
- `y`  out  10  recovered vertical position
- `video_on`  out  1  `locked` and `x < HD` and `y < VD`
- `locked`  out  1  raster lock achieved
- `h_err`  out  1  sticky: line period mismatch seen while locked
- `v_err`  out  1  sticky: frame period mismatch seen while locked
- `err_cnt`  out  8  lock-loss count, saturates at 255

## Operation
- All state advances only on cycles with `p_tick` = 1; other cycles hold everything.
- Sample `hsync`/`vsync` into previous-value registers each tick; rising edge = current 1, previous 0.
- H counter: on hsync rise load `HD+HB` (656); else increment, wrap `HTOTAL-1` → 0.
- V counter: on vsync rise load `VD+VB` (513); else increment when H counter wraps, wrap `VTOTAL-1` → 0.
- Line period counter (11 bit): counts ticks between hsync rises; saturates at 2047.
- Line count between vsync rises (10 bit), compared to `VTOTAL`.
- States:
  - SEARCH: `locked`=0, good-line count 0. First hsync rise → HLOCK.
  - HLOCK: each hsync rise: period = `HTOTAL` → good count +1, else good count 0. Good count ≥ `LOCK_LINES` and vsync rise with line count = `VTOTAL` → LOCKED. First vsync rise after entry only arms the line count (not checked).
  - LOCKED: `locked`=1. Hsync rise with period ≠ `HTOTAL` → set `h_err`, → SEARCH. Vsync rise with line count ≠ `VTOTAL` → set `v_err`, → SEARCH. Each LOCKED→SEARCH increments `err_cnt` (saturating).
- Timeout: period counter reaching `2*HTOTAL` (1600) with no hsync rise → SEARCH from any state; from LOCKED also sets `h_err` and increments `err_cnt`.
- Simultaneous hsync and vsync rise on same tick: both checks evaluated; a single lock loss increments `err_cnt` by 1 only.
- `h_err`, `v_err`, `err_cnt` clear only on `reset`.
- `x`,`y` track counters in all states; `video_on` forced 0 unless `locked`.

## Timing
- Reset: `x`=0, `y`=0, `video_on`=0, `locked`=0, `h_err`=0, `v_err`=0, `err_cnt`=0, state SEARCH; reset mid-frame takes effect immediately (async) and requires full re-lock.
- All outputs registered; a sync edge sampled on tick N is reflected in `x`/`y`/flags on the `clk_100MHz` edge that samples tick N (visible the cycle after `p_tick`).
- `x`=656 on the tick where hsync is first seen high; `y`=513 on the tick where vsync is first seen high.
- `locked` rises on the tick of the qualifying vsync rise; falls on the tick of the failing check.
- Minimum lock time from reset with clean input: up to one partial frame + one full frame.

## Test plan
- Clean 800x525 stream from the timing generator, from reset → `locked`=1 within 2 frames; thereafter `x`,`y` equal generator counters every tick; `video_on` matches; `err_cnt`=0 after 10 frames.
- Locked, one line stretched to 801 ticks → `h_err`=1, `locked`=0, `err_cnt`=1; re-lock by end of next full frame.
- Locked, one frame shortened to 524 lines → `v_err`=1, `locked`=0, `err_cnt`=1, `h_err`=0.
- Locked, hsync held low 1600 ticks → timeout: `locked`=0, `h_err`=1, `err_cnt`=1.
- Force 300 lock losses → `err_cnt` saturates at 255.
- Assert `reset` mid-line while locked → all outputs 0 next cycle; re-lock normally after release.
